// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings, defaults and width helpers for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Controller states (kept as plain constants for legacy tooling)
  localparam logic [0:0] PCTRL_RUN  = 1'b0;
  localparam logic [0:0] PCTRL_HOLD = 1'b1;

  // Default pipeline depth and watchdog limit
  localparam int PCTRL_STAGES  = 5;
  localparam int PCTRL_TIMEOUT = 15;

  // clog2 that never returns zero, so every derived bus is at least 1 bit wide
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pipe_ctrl_prio_enc.sv
// Highest-set-bit priority encoder: index of the oldest requesting stage.
module prio_enc
  import pipe_ctrl_pkg::*;
#(
  parameter int N = 5,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);

  // Later (higher) indices overwrite earlier ones, so the highest set bit wins
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        idx_o = W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall/bubble masks, latched load-use
// HOLD released by unpause, flush-vs-pause priority and a HOLD watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES  = PCTRL_STAGES,
  parameter int TIMEOUT = PCTRL_TIMEOUT,
  parameter int IW      = clog2_min1(STAGES),
  parameter int CW      = clog2_min1(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] pause_req,
  input  logic              unpause,
  input  logic [STAGES-1:0] flush_req,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] bubble,
  output logic              paused,
  output logic [IW-1:0]     hold_stage,
  output logic              timeout_err
);

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] h_q, h_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [IW-1:0] p_idx, f_idx;
  logic          p_vld, f_vld;

  prio_enc #(.N(STAGES), .W(IW)) u_pause_enc (
    .req_i (pause_req),
    .idx_o (p_idx),
    .vld_o (p_vld)
  );

  prio_enc #(.N(STAGES), .W(IW)) u_flush_enc (
    .req_i (flush_req),
    .idx_o (f_idx),
    .vld_o (f_vld)
  );

  logic in_hold, cancel, wd_fire, release_c, evaluate;
  logic take_pause, take_flush, keep_hold;
  logic mask_stall, mask_flush;
  logic [IW-1:0] mask_idx;

  // Decode this cycle's action. An older flush cancels a hold outright (even
  // over unpause/watchdog); a release re-evaluates the inputs exactly as RUN.
  always_comb begin
    in_hold    = (state_q == PCTRL_HOLD);
    cancel     = in_hold && f_vld && (f_idx > h_q);
    wd_fire    = (TIMEOUT > 0) && (int'(cnt_q) == TIMEOUT);
    release_c  = in_hold && !cancel && (unpause || wd_fire);
    evaluate   = !in_hold || release_c;
    take_pause = evaluate && p_vld && (!f_vld || (p_idx >= f_idx));
    take_flush = (evaluate && !take_pause && f_vld) || cancel;
    keep_hold  = in_hold && !cancel && !release_c;
    mask_stall = !rst && (take_pause || keep_hold);
    mask_flush = !rst && take_flush;
    mask_idx   = take_pause ? p_idx : h_q;
  end

  // Per-stage masks: stall 0..idx, bubble just above the stall boundary,
  // flush bubbles everything younger than the redirecting stage.
  for (genvar g = 0; g < STAGES; g++) begin : g_mask
    assign stall[g]  = mask_stall && (int'(mask_idx) >= g);
    assign bubble[g] = rst
                    || (mask_stall && (int'(mask_idx) + 1 == g))
                    || (mask_flush && (int'(f_idx) > g));
  end

  // Next state: enter HOLD on a winning pause, count while held, otherwise RUN
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (take_pause) begin
      state_d = PCTRL_HOLD;
      h_d     = p_idx;
      cnt_d   = CW'(1);
    end else if (keep_hold) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else begin
      state_d = PCTRL_RUN;
      cnt_d   = '0;
    end
    if (release_c && !unpause) err_d = 1'b1;
  end

  // State, held index, counter and sticky watchdog flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PCTRL_RUN;
      h_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign paused      = in_hold && !rst;
  assign hold_stage  = h_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic,
// all compared against a cycle-level behavioural model of the hazard rules.
module tb_pipe_ctrl;

  localparam int S    = 5;
  localparam int TO   = 8;
  localparam int CMAX = 15;   // 4-bit saturating counter for TIMEOUT=8

  logic         clk = 1'b0;
  logic         rst;
  logic [S-1:0] pause_req, flush_req;
  logic         unpause;
  logic [S-1:0] stall, bubble;
  logic         paused;
  logic [2:0]   hold_stage;
  logic         timeout_err;

  int checks   = 0;
  int failures = 0;

  // model state
  bit m_hold = 1'b0;
  int m_h    = 0;
  int m_cnt  = 0;
  bit m_err  = 1'b0;

  pipe_ctrl #(.STAGES(S), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .pause_req   (pause_req),
    .unpause     (unpause),
    .flush_req   (flush_req),
    .stall       (stall),
    .bubble      (bubble),
    .paused      (paused),
    .hold_stage  (hold_stage),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check the combinational outputs mid-cycle,
  // then advance the model across the clock edge.
  task automatic step(input string tag, input bit r, input logic [S-1:0] pr,
                      input bit up, input logic [S-1:0] fr);
    int p, f, nhh, nc;
    bit nh, ne, run_eval;
    logic [S-1:0] es, eb;
    rst = r; pause_req = pr; unpause = up; flush_req = fr;
    #4;
    p = -1; f = -1;
    for (int i = 0; i < S; i++) begin
      if (pr[i]) p = i;
      if (fr[i]) f = i;
    end
    es = '0; eb = '0;
    nh = m_hold; nhh = m_h; nc = m_cnt; ne = m_err; run_eval = 1'b0;
    if (r) begin
      eb = '1; nh = 1'b0; nhh = 0; nc = 0; ne = 1'b0;
    end else if (m_hold) begin
      if (f > m_h) begin
        for (int i = 0; i < f; i++) eb[i] = 1'b1;
        nh = 1'b0;
      end else if (up || (TO > 0 && m_cnt == TO)) begin
        if (!up) ne = 1'b1;
        run_eval = 1'b1;
      end else begin
        for (int i = 0; i <= m_h; i++) es[i] = 1'b1;
        if (m_h + 1 < S) eb[m_h+1] = 1'b1;
        nc = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end
    end else begin
      run_eval = 1'b1;
    end
    if (run_eval) begin
      if (p >= 0 && p >= f) begin
        for (int i = 0; i <= p; i++) es[i] = 1'b1;
        if (p + 1 < S) eb[p+1] = 1'b1;
        nh = 1'b1; nhh = p; nc = 1;
      end else begin
        for (int i = 0; i < f; i++) eb[i] = 1'b1;
        nh = 1'b0;
      end
    end
    chk({tag, ".stall"},  32'(stall),  32'(es));
    chk({tag, ".bubble"}, 32'(bubble), 32'(eb));
    chk({tag, ".paused"}, 32'(paused), 32'(m_hold && !r));
    chk({tag, ".err"},    32'(timeout_err), 32'(m_err));
    if (m_hold && !r) chk({tag, ".hold_stage"}, 32'(hold_stage), 32'(m_h));
    @(posedge clk);
    #1;
    m_hold = nh; m_h = nhh; m_cnt = nc; m_err = ne;
  endtask

  initial begin
    // Unchecked first reset edge so register state is defined
    rst = 1'b1; pause_req = '0; unpause = 1'b0; flush_req = '0;
    @(posedge clk);
    #1;

    // Reset held for two cycles, then release
    step("rst0", 1, 5'b00000, 0, 5'b00000);
    step("rst1", 1, 5'b00000, 0, 5'b00000);
    step("idle", 0, 5'b00000, 0, 5'b00000);

    // Load-use at ID, held, released by unpause
    step("lu_enter", 0, 5'b00010, 0, 5'b00000);
    step("lu_hold1", 0, 5'b00000, 0, 5'b00000);
    step("lu_hold2", 0, 5'b00000, 0, 5'b00000);
    step("lu_hpause", 0, 5'b01000, 0, 5'b00000);
    step("lu_unp",   0, 5'b00000, 1, 5'b00000);
    step("lu_run",   0, 5'b00000, 0, 5'b00000);
    step("run_unp",  0, 5'b00000, 1, 5'b00000);

    // Branch flush, flush beating a younger pause, f=0 no-op
    step("br_flush", 0, 5'b00000, 0, 5'b00100);
    step("br_both",  0, 5'b00010, 0, 5'b00100);
    step("br_f0",    0, 5'b00000, 0, 5'b00001);

    // Older pause swallows the flush; then a hold cancelled by an older flush
    step("pr_pause", 0, 5'b01000, 0, 5'b00100);
    step("pr_unp",   0, 5'b00000, 1, 5'b00000);
    step("pr_enter", 0, 5'b00010, 0, 5'b00000);
    step("pr_fign",  0, 5'b00000, 0, 5'b00010);
    step("pr_fcan",  0, 5'b00000, 1, 5'b00100);
    step("pr_run",   0, 5'b00000, 0, 5'b00000);

    // Watchdog: hold without unpause until forced release; flag is sticky
    step("wd_enter", 0, 5'b00010, 0, 5'b00000);
    for (int i = 0; i < 10; i++) step("wd_wait", 0, 5'b00000, 0, 5'b00000);
    step("wd_sticky", 0, 5'b00000, 0, 5'b00000);

    // Back-to-back: unpause with a new pause re-enters HOLD, counter restarts
    step("bb_enter", 0, 5'b00010, 0, 5'b00000);
    step("bb_hold",  0, 5'b00000, 0, 5'b00000);
    step("bb_again", 0, 5'b00010, 1, 5'b00000);
    for (int i = 0; i < 9; i++) step("bb_wait", 0, 5'b00000, 0, 5'b00000);

    // Reset in the middle of a hold clears everything
    step("rh_enter", 0, 5'b10000, 0, 5'b00000);
    step("rh_rst",   1, 5'b00000, 0, 5'b00000);
    step("rh_after", 0, 5'b00000, 0, 5'b00000);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bit r, up;
      logic [S-1:0] pr, fr;
      r  = ($urandom_range(63) == 0);
      pr = ($urandom_range(3) == 0) ? S'($urandom) : '0;
      fr = ($urandom_range(3) == 0) ? S'($urandom) : '0;
      up = (n < 200) ? ($urandom_range(3) == 0) : ($urandom_range(11) == 0);
      step("rnd", r, pr, up, fr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
